// File: rtl/sample_loader_pkg.sv
// Shared types and sizing helpers for the UART-fed I/Q sample player.
package sample_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    LOAD_HI = 3'd2,
    READY   = 3'd3,
    PLAY    = 3'd4
  } state_t;

  // The SPRAM primitive always takes a 14-bit word address.
  localparam int SPRAM_AW = 14;

  function automatic int calc_sym_cnt(input int clk_freq, input int sym_rate);
    return clk_freq / sym_rate;
  endfunction

  function automatic int calc_scw(input int sym_cnt);
    return $clog2(sym_cnt);
  endfunction

  function automatic int calc_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/acia_rx.sv
// UART 8N1 byte receiver: mid-bit sampling from a sym_cnt-clock bit period.
// rx_stb pulses for one clock with rx_dat valid once a good stop bit is seen.
module acia_rx #(
  parameter int SCW     = 16,
  parameter int sym_cnt = 40000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_dat,
  output logic       rx_stb
);

  localparam logic [SCW-1:0] HALF_CNT = SCW'(sym_cnt / 2 - 1);
  localparam logic [SCW-1:0] FULL_CNT = SCW'(sym_cnt - 1);

  logic           rx_meta_reg;
  logic           rx_sync_reg;
  logic           busy_reg;
  logic [SCW-1:0] cnt_reg;
  logic [3:0]     bit_idx_reg;
  logic [7:0]     shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      busy_reg    <= 1'b0;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      rx_dat      <= '0;
      rx_stb      <= 1'b0;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_stb      <= 1'b0;
      if (!busy_reg) begin
        // Start edge: first sample lands half a bit later, mid start bit.
        if (!rx_sync_reg) begin
          busy_reg    <= 1'b1;
          cnt_reg     <= HALF_CNT;
          bit_idx_reg <= '0;
        end
      end else if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end else begin
        cnt_reg <= FULL_CNT;
        if (bit_idx_reg == 4'd0) begin
          if (rx_sync_reg) begin
            busy_reg <= 1'b0;
          end else begin
            bit_idx_reg <= 4'd1;
          end
        end else if (bit_idx_reg <= 4'd8) begin
          shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
          bit_idx_reg <= bit_idx_reg + 1'b1;
        end else begin
          busy_reg <= 1'b0;
          if (rx_sync_reg) begin
            rx_dat <= shift_reg;
            rx_stb <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/sample_loader.sv
// UART-fed I/Q sample player: byte pairs are packed into {Q,I} words in SPRAM, then replayed per stb.
// Define PLAY_LOOP_EN to make playback wrap gaplessly instead of stopping after the last word.
module sample_loader
  import sample_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 48000000,
  parameter int SYM_RATE    = 1200,
  parameter int DEPTH_LOG2  = 8,
  parameter int TIMEOUT_CYC = 40 * calc_sym_cnt(CLK_FREQ, SYM_RATE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fpga_rx,
  input  logic       play,
  input  logic       stb,
  output logic [7:0] i_value,
  output logic [7:0] q_value,
  output logic       sample_vld,
  output logic       loaded,
  output logic       playing,
  output logic       load_err
);

  localparam int SYM_CNT = calc_sym_cnt(CLK_FREQ, SYM_RATE);
  localparam int SCW     = calc_scw(SYM_CNT);
  localparam int DEPTH   = calc_depth(DEPTH_LOG2);
  localparam int TO_W    = $clog2(TIMEOUT_CYC);

  localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = DEPTH_LOG2'(DEPTH - 1);
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  logic [7:0] rx_dat;
  logic       rx_stb;

  acia_rx #(
    .SCW     (SCW),
    .sym_cnt (SYM_CNT)
  ) u_acia_rx (
    .clk    (clk),
    .rst    (rst),
    .rx     (fpga_rx),
    .rx_dat (rx_dat),
    .rx_stb (rx_stb)
  );

  state_t                state_reg, state_next;
  logic [DEPTH_LOG2-1:0] addr_reg, addr_next;
  logic [7:0]            lo_reg, lo_next;
  logic                  loaded_reg, loaded_next;
  logic                  load_err_reg, load_err_next;
  logic [TO_W-1:0]       to_cnt_reg, to_cnt_next;
  logic                  play_done_reg, play_done_next;
  logic                  rd_pend_reg;
  logic                  vld_reg;
  logic [15:0]           word_reg;

  logic                  wr_go;
  logic                  rd_go;
  logic                  timeout;

  assign timeout = (to_cnt_reg == TO_LAST);

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    lo_next        = lo_reg;
    loaded_next    = loaded_reg;
    load_err_next  = load_err_reg;
    to_cnt_next    = '0;
    play_done_next = play_done_reg;
    wr_go          = 1'b0;
    rd_go          = 1'b0;

    // A finished one-shot holds off replay until play is released.
    if (!play) begin
      play_done_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (rx_stb) begin
          lo_next       = rx_dat;
          load_err_next = 1'b0;
          addr_next     = '0;
          state_next    = LOAD_HI;
        end
      end
      LOAD_LO: begin
        if (rx_stb) begin
          lo_next    = rx_dat;
          state_next = LOAD_HI;
        end else if (timeout) begin
          load_err_next = 1'b1;
          addr_next     = '0;
          state_next    = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      LOAD_HI: begin
        if (rx_stb) begin
          wr_go = 1'b1;
          if (addr_reg == LAST_ADDR) begin
            loaded_next = 1'b1;
            addr_next   = '0;
            state_next  = READY;
          end else begin
            addr_next  = addr_reg + 1'b1;
            state_next = LOAD_LO;
          end
        end else if (timeout) begin
          load_err_next = 1'b1;
          addr_next     = '0;
          state_next    = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      READY: begin
        if (play && !play_done_reg) begin
          addr_next  = '0;
          state_next = PLAY;
        end else if (rx_stb) begin
          lo_next       = rx_dat;
          load_err_next = 1'b0;
          loaded_next   = 1'b0;
          addr_next     = '0;
          state_next    = LOAD_HI;
        end
      end
      PLAY: begin
        if (!play) begin
          addr_next  = '0;
          state_next = READY;
        end else if (stb) begin
          rd_go = 1'b1;
          if (addr_reg == LAST_ADDR) begin
            addr_next = '0;
`ifndef PLAY_LOOP_EN
            play_done_next = 1'b1;
            state_next     = READY;
`endif
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end
      end
      default: begin
        addr_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      lo_reg        <= '0;
      loaded_reg    <= 1'b0;
      load_err_reg  <= 1'b0;
      to_cnt_reg    <= '0;
      play_done_reg <= 1'b0;
      rd_pend_reg   <= 1'b0;
      vld_reg       <= 1'b0;
      word_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      lo_reg        <= lo_next;
      loaded_reg    <= loaded_next;
      load_err_reg  <= load_err_next;
      to_cnt_reg    <= to_cnt_next;
      play_done_reg <= play_done_next;
      // Read pipeline runs independent of state so an in-flight sample always lands.
      rd_pend_reg   <= rd_go;
      vld_reg       <= rd_pend_reg;
      if (rd_pend_reg) begin
        word_reg <= ram_dout;
      end
    end
  end

  logic [SPRAM_AW-1:0] ram_addr;
  logic [15:0]         ram_din;
  logic [15:0]         ram_dout;
  logic                ram_we;

  assign ram_addr = SPRAM_AW'(addr_reg);
  assign ram_din  = {rx_dat, lo_reg};
  assign ram_we   = wr_go && !rst;

`ifdef SYNTHESIS
  SB_SPRAM256KA u_spram (
    .ADDRESS    (ram_addr),
    .DATAIN     (ram_din),
    .MASKWREN   (4'hF),
    .WREN       (ram_we),
    .CHIPSELECT (1'b1),
    .CLOCK      (clk),
    .STANDBY    (1'b0),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (ram_dout)
  );
`else
  // Behavioural stand-in with the primitive's one-cycle registered read.
  logic [15:0] spram_mem [0:(1<<SPRAM_AW)-1];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      spram_mem[ram_addr] <= ram_din;
    end else begin
      ram_dout <= spram_mem[ram_addr];
    end
  end
`endif

  assign i_value    = word_reg[7:0];
  assign q_value    = word_reg[15:8];
  assign sample_vld = vld_reg;
  assign loaded     = loaded_reg;
  assign playing    = (state_reg == PLAY);
  assign load_err   = load_err_reg;

endmodule

// File: tb/tb_sample_loader.sv
// Randomized self-checking bench for sample_loader against a byte-list/word-array reference model.
module tb_sample_loader;

  localparam int DEPTH_LOG2   = 2;
  localparam int DEPTH        = 1 << DEPTH_LOG2;
  localparam int CLKS_PER_BIT = 4;
  localparam int TIMEOUT      = 40 * CLKS_PER_BIT;
`ifdef PLAY_LOOP_EN
  localparam int N_PLAY = 6;
`else
  localparam int N_PLAY = DEPTH;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       fpga_rx;
  logic       play;
  logic       stb;
  logic [7:0] i_value;
  logic [7:0] q_value;
  logic       sample_vld;
  logic       loaded;
  logic       playing;
  logic       load_err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  load_bytes [2*DEPTH];
  logic [15:0] mem_model  [DEPTH];
  logic [15:0] last_word = 16'h0000;

  always #5 clk = ~clk;

  sample_loader #(
    .CLK_FREQ   (4800),
    .SYM_RATE   (1200),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fpga_rx    (fpga_rx),
    .play       (play),
    .stb        (stb),
    .i_value    (i_value),
    .q_value    (q_value),
    .sample_vld (sample_vld),
    .loaded     (loaded),
    .playing    (playing),
    .load_err   (load_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      fpga_rx = frame[k];
      tick(CLKS_PER_BIT);
    end
  endtask

  // Model: even byte is I (low half), odd byte is Q (high half) of word k.
  task automatic load_all();
    for (int k = 0; k < 2 * DEPTH; k++) send_byte(load_bytes[k]);
    for (int w = 0; w < DEPTH; w++) mem_model[w] = {load_bytes[2*w+1], load_bytes[2*w]};
    tick(4);
    $display("load: %0d words, word0=%04h", DEPTH, mem_model[0]);
    check("loaded", 32'(loaded), 32'd1);
    check("ready_idle", 32'(playing), 32'd0);
    check("load_err_clear", 32'(load_err), 32'd0);
  endtask

  task automatic do_stb(input int idx, input int gap);
    logic [15:0] w;
    w = mem_model[idx % DEPTH];
    stb = 1'b1;
    tick(1);
    stb = 1'b0;
    check("vld_early", 32'(sample_vld), 32'd0);
    tick(1);
    check("vld", 32'(sample_vld), 32'd1);
    check("i_value", 32'(i_value), 32'(w[7:0]));
    check("q_value", 32'(q_value), 32'(w[15:8]));
    $display("sample %0d: i=%02h q=%02h", idx, i_value, q_value);
    last_word = w;
    tick(gap);
  endtask

  task automatic stb_run();
    for (int i = 0; i < N_PLAY; i++) do_stb(i, int'($urandom_range(1, 8)));
    tick(2);
`ifdef PLAY_LOOP_EN
    check("loop_playing", 32'(playing), 32'd1);
`else
    check("one_shot_done", 32'(playing), 32'd0);
    check("loaded_after_play", 32'(loaded), 32'd1);
`endif
    play = 1'b0;
    tick(2);
    check("stopped", 32'(playing), 32'd0);
    stb = 1'b1;
    tick(1);
    stb = 1'b0;
    tick(1);
    check("stb_ignored", 32'(sample_vld), 32'd0);
    check("i_hold", 32'(i_value), 32'(last_word[7:0]));
    check("q_hold", 32'(q_value), 32'(last_word[15:8]));
  endtask

  task automatic play_run();
    play = 1'b1;
    tick(2);
    check("playing", 32'(playing), 32'd1);
    stb_run();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_i"}, 32'(i_value), 32'd0);
    check({tag, "_q"}, 32'(q_value), 32'd0);
    check({tag, "_vld"}, 32'(sample_vld), 32'd0);
    check({tag, "_loaded"}, 32'(loaded), 32'd0);
    check({tag, "_playing"}, 32'(playing), 32'd0);
    check({tag, "_err"}, 32'(load_err), 32'd0);
    last_word = 16'h0000;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fpga_rx = 1'b1; play = 1'b0; stb = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(1);
    check_reset_outputs("reset");

    // Reference vector from the datasheet.
    for (int k = 0; k < 2 * DEPTH; k++) load_bytes[k] = 8'(8'h11 * (k + 1));
    load_all();
    play_run();

    // Random reload from READY.
    for (int k = 0; k < 2 * DEPTH; k++) load_bytes[k] = 8'($urandom);
    load_all();
    play_run();

    // Inter-byte timeout aborts a partial load.
    for (int k = 0; k < 3; k++) send_byte(8'($urandom));
    tick(TIMEOUT + 20);
    $display("timeout: load_err=%0d loaded=%0d", load_err, loaded);
    check("timeout_err", 32'(load_err), 32'd1);
    check("timeout_loaded", 32'(loaded), 32'd0);
    check("timeout_idle", 32'(playing), 32'd0);
    play = 1'b1;
    tick(3);
    check("no_play_unloaded", 32'(playing), 32'd0);
    play = 1'b0;
    send_byte(8'($urandom));
    tick(4);
    check("err_cleared", 32'(load_err), 32'd0);
    tick(TIMEOUT + 20);
    check("timeout_err2", 32'(load_err), 32'd1);

    // Bytes arriving during PLAY are dropped.
    for (int k = 0; k < 2 * DEPTH; k++) load_bytes[k] = 8'($urandom);
    load_all();
    play = 1'b1;
    tick(2);
    check("playing_rx", 32'(playing), 32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick(4);
    $display("rx during play: playing=%0d loaded=%0d", playing, loaded);
    check("rx_play_stays", 32'(playing), 32'd1);
    check("rx_play_loaded", 32'(loaded), 32'd1);
    check("rx_play_i_hold", 32'(i_value), 32'(last_word[7:0]));
    check("rx_play_q_hold", 32'(q_value), 32'(last_word[15:8]));
    stb_run();

    // Reset in the middle of a load.
    for (int k = 0; k < 5; k++) send_byte(8'($urandom));
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check_reset_outputs("midload_rst");
    for (int k = 0; k < 2 * DEPTH; k++) load_bytes[k] = 8'($urandom);
    load_all();
    play_run();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
